// File: rtl/ofb_decode.sv
// AES-128 OFB-mode decryptor: keystream ks(i) = E(key, ks(i-1)) seeded with iv,
// plaintext = ciphertext XOR keystream, one block per GEN/ACCEPT/EMIT round.
module ofb_decode #(
    parameter int MAX_BLOCKS = 65536,
    parameter int CNT_W      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [127:0]     iv,
    input  logic             in_valid,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [127:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        ACCEPT = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BLOCKS);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xt(aa);
        end
        return acc;
    endfunction

    // S-box as affine(b^254): the multiplicative inverse in GF(2^8), 0 maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte k of the state sits at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic final_round);
        logic [7:0]   b  [16];
        logic [7:0]   sh [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sh[r+4*c] = b[r + 4*((c+r)%4)];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
            if (final_round)
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] rk;
        logic [7:0]   rc;
        s  = pt ^ k;
        rk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = next_key(rk, rc);
            s  = aes_round(s, rk, r == 10);
            rc = xt(rc);
        end
        return s;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [127:0]       r_key;
    logic [127:0]       r_ks;
    logic [127:0]       r_out_data;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_blk_count;
    logic [127:0]       w_ks_next;
    logic               w_cnt_hit;
    logic               w_in_ready;
    logic               w_out_valid;

    // Single-cycle combinational AES; only consumed in GEN, so stalls never advance it.
    assign w_ks_next = aes_enc(r_key, r_ks);
    assign w_cnt_hit = (r_blk_count + 1'b1) == MAX_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_ks        <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: if (start) begin
                    r_key       <= key;
                    r_ks        <= iv;
                    r_blk_count <= '0;
                end
                GEN: r_ks <= w_ks_next;
                ACCEPT: if (in_valid) begin
                    r_out_data <= in_data ^ r_ks;
                    r_out_last <= in_last | w_cnt_hit;
                end
                EMIT: if (out_ready && r_blk_count != MAX_CNT)
                    r_blk_count <= r_blk_count + 1'b1;
                default: ;
            endcase
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE:   if (start) w_state_next = GEN;
            GEN:    w_state_next = ACCEPT;
            ACCEPT: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_next = EMIT;
            end
            EMIT: begin
                w_out_valid = 1'b1;
                if (out_ready) w_state_next = r_out_last ? IDLE : GEN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign blk_count = r_blk_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ofb_decode.sv
// Bench for ofb_decode: directed and randomized messages checked against a
// table-driven AES/OFB reference model and an expected-plaintext queue.
module tb_ofb_decode;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [127:0] key, iv, in_data;
    logic         in_valid, in_last, out_ready;
    logic         sel;

    logic         a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [127:0] a_out_data;
    logic [16:0]  a_blk_count;
    logic [1:0]   a_dbg;
    logic         b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [127:0] b_out_data;
    logic [1:0]   b_blk_count;
    logic [1:0]   b_dbg;

    logic         m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [127:0] m_out_data;
    logic [16:0]  m_blk_count;

    always #5 clk = ~clk;

    ofb_decode dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key), .iv(iv),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(out_ready), .busy(a_busy), .blk_count(a_blk_count), .dbg_state(a_dbg)
    );

    ofb_decode #(.MAX_BLOCKS(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key), .iv(iv),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(out_ready), .busy(b_busy), .blk_count(b_blk_count), .dbg_state(b_dbg)
    );

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_out_data  = sel ? b_out_data  : a_out_data;
    assign m_blk_count = sel ? {15'd0, b_blk_count} : a_blk_count;

    int           n_pass = 0;
    int           n_fail = 0;
    int           n_total = 0;
    logic [7:0]   sb [256];
    logic [127:0] m_key, m_ks;
    logic [127:0] exp_q[$];
    int           exp_cnt;

    // ---------------- reference model ----------------
    function automatic logic [7:0] rxt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walks generator 3 through the field: p = 3^n, q = 3^-n, sb[p] = affine(q).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3, tt;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = rxt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sb[st[i]];
            for (int i = 0; i < 16; i++) st[i] = tmp[(i + 4*(i%4)) % 16];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    tt = a0 ^ a1 ^ a2 ^ a3;
                    st[4*c]   = a0 ^ tt ^ rxt(a0 ^ a1);
                    st[4*c+1] = a1 ^ tt ^ rxt(a1 ^ a2);
                    st[4*c+2] = a2 ^ tt ^ rxt(a2 ^ a3);
                    st[4*c+3] = a3 ^ tt ^ rxt(a3 ^ a0);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_msg(input logic [127:0] k, input logic [127:0] v, input logic use_b);
        sel = use_b;
        key = k;
        iv  = v;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        iv  = {$urandom, $urandom, $urandom, $urandom};
        m_key   = k;
        m_ks    = v;
        exp_cnt = 0;
        check("busy_after_start", 128'(m_busy), 128'(1'b1));
    endtask

    task automatic send_block(input logic [127:0] data, input logic last, input int stall,
                              input logic exp_last);
        logic [127:0] exp;
        int n;
        m_ks = aes_ref(m_key, m_ks);
        exp_q.push_back(data ^ m_ks);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        n = 0;
        while (!m_in_ready && n < 20) begin
            step();
            n++;
        end
        check("accept_in_time", 128'(n < 20), 128'(1'b1));
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
        exp = exp_q.pop_front();
        check("out_valid_latency", 128'(m_out_valid), 128'(1'b1));
        check("out_data", m_out_data, exp);
        check("out_last", 128'(m_out_last), 128'(exp_last));
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            step();
            check("stall_out_valid", 128'(m_out_valid), 128'(1'b1));
            check("stall_out_data", m_out_data, exp);
            check("stall_out_last", 128'(m_out_last), 128'(exp_last));
            check("stall_in_ready", 128'(m_in_ready), 128'(1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        check("blk_count", 128'(m_blk_count), 128'(exp_cnt));
        check("out_valid_after_hs", 128'(m_out_valid), 128'(1'b0));
        check("busy_after_hs", 128'(m_busy), 128'(!exp_last));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [127:0] k0, v0, ct;
        int len;
        build_sbox();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        key = '0; iv = '0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        check("rst_in_ready", 128'(a_in_ready), 128'(1'b0));
        check("rst_out_last", 128'(a_out_last), 128'(1'b0));
        check("rst_busy", 128'(a_busy), 128'(1'b0));
        check("rst_out_data", a_out_data, 128'h0);
        check("rst_blk_count", 128'(a_blk_count), 128'h0);
        check("rst_state", 128'(a_dbg), 128'h0);
        rst = 1'b0;
        step();

        // Known-answer vector: independent check of both model and DUT.
        check("kat_model", aes_ref(128'h5468617473206D79204B756E67204675,
                                   128'h54776F204F6E65204E696E652054776F),
              128'h29C3505F571420F6402299B31A02D73A);
        begin_msg(128'h5468617473206D79204B756E67204675, 128'h54776F204F6E65204E696E652054776F, 1'b0);
        send_block(128'h0, 1'b1, 0, 1'b1);
        check("kat_dut", a_out_data, 128'h29C3505F571420F6402299B31A02D73A);

        // Single block with zero ciphertext returns E(key, iv).
        k0 = 128'h0f1571c947d9e8590cb7add6af7f6798;
        v0 = 128'h5468617473206D79204B756E67204675;
        begin_msg(k0, v0, 1'b0);
        send_block(128'h0, 1'b1, 1, 1'b1);
        check("zero_block_state", 128'(a_dbg), 128'h0);

        // Round trip: ciphertexts built from plaintexts 0..3, block 2 stalled 5 cycles.
        begin_msg(k0, v0, 1'b0);
        ct = v0;
        for (int i = 0; i < 4; i++) begin
            ct = aes_ref(k0, ct);
            send_block(ct ^ 128'(i), 1'(i == 3), (i == 1) ? 5 : 0, 1'(i == 3));
            check("roundtrip_plain", a_out_data, 128'(i));
        end

        // Start pulsed mid-message with another iv is ignored.
        begin_msg(k0, v0, 1'b0);
        send_block(128'h1111, 1'b0, 0, 1'b0);
        iv = ~v0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        send_block(128'h2222, 1'b0, 2, 1'b0);
        send_block(128'h3333, 1'b1, 0, 1'b1);

        // Count limit on the MAX_BLOCKS=3 instance: last forced on block 3.
        begin_msg(k0, v0, 1'b1);
        for (int i = 0; i < 3; i++)
            send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, i, 1'(i == 2));
        check("limit_state", 128'(b_dbg), 128'h0);
        sel = 1'b0;

        // Abort in EMIT of block 2, then restart with the same key/iv.
        begin_msg(k0, v0, 1'b0);
        send_block(128'hABCD, 1'b0, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 128'h5555;
        in_last  = 1'b0;
        for (int n = 0; n < 4 && !a_in_ready; n++) step();
        step();
        in_valid = 1'b0;
        check("abort_in_emit", 128'(a_out_valid), 128'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(a_out_valid), 128'(1'b0));
        check("abort_in_ready", 128'(a_in_ready), 128'(1'b0));
        check("abort_out_last", 128'(a_out_last), 128'(1'b0));
        check("abort_busy", 128'(a_busy), 128'(1'b0));
        check("abort_out_data", a_out_data, 128'h0);
        check("abort_blk_count", 128'(a_blk_count), 128'h0);
        rst = 1'b0;
        step();
        step();
        check("abort_waits_idle", 128'(a_busy), 128'(1'b0));
        begin_msg(k0, v0, 1'b0);
        send_block(128'h7777, 1'b1, 0, 1'b1);
        check("abort_restart", a_out_data, aes_ref(k0, v0) ^ 128'h7777);

        // Randomized messages.
        for (int m = 0; m < 5; m++) begin
            begin_msg({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                send_block({$urandom, $urandom, $urandom, $urandom}, 1'(i == len - 1),
                           $urandom_range(0, 3), 1'(i == len - 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
